// File: rtl/norm_weight_replay_buffer_if.sv
// Load and replay handshake bundle for the normalization weight replay buffer.
// The slave modport is the buffer itself; the master modport is its environment
// (weight loader on one side, normalization consumer on the other).
interface norm_weight_replay_buffer_if #(
    parameter int N           = 4,
    parameter int SCALE_WIDTH = 8
);
    logic [N-1:0][SCALE_WIDTH-1:0] load_data;
    logic                          load_valid;
    logic                          load_ready;
    logic [N-1:0][SCALE_WIDTH-1:0] weight_data;
    logic                          weight_valid;
    logic                          weight_ready;
    logic                          loaded;
    logic                          frame_done;

    modport slave (
        input  load_data, load_valid, weight_ready,
        output load_ready, weight_data, weight_valid, loaded, frame_done
    );

    modport master (
        output load_data, load_valid, weight_ready,
        input  load_ready, weight_data, weight_valid, loaded, frame_done
    );
endinterface

// File: rtl/norm_weight_replay_buffer.sv
// Weight replay buffer for the normalization layers.
// One full weight frame is loaded tile by tile, then replayed tile-for-tile in
// the data stream order for every frame until cleared or reset.
module norm_weight_replay_buffer #(
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2,
    parameter int CHANNELS     = 2,
    parameter int SCALE_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    norm_weight_replay_buffer_if.slave bus
);
    localparam int N         = COMPUTE_DIM0 * COMPUTE_DIM1;
    localparam int NUM_ITERS = (TOTAL_DIM0 / COMPUTE_DIM0) * (TOTAL_DIM1 / COMPUTE_DIM1) * CHANNELS;
    localparam int PTR_W     = (NUM_ITERS > 1) ? $clog2(NUM_ITERS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_ITERS - 1);

    typedef logic [N-1:0][SCALE_WIDTH-1:0] tile_t;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              frame_done_q, frame_done_d;
    tile_t             mem_q [NUM_ITERS];

    logic              mem_we;
    logic              load_ready;
    logic              weight_valid;
    logic              load_fire;
    logic              weight_fire;

    // Handshake qualifiers; load_ready is held low while reset is asserted
    assign load_ready   = (state_q == ST_LOAD) && !rst;
    assign weight_valid = (state_q == ST_REPLAY);
    assign load_fire    = bus.load_valid && load_ready;
    assign weight_fire  = weight_valid && bus.weight_ready;

    // Next-state logic: load until the frame is full, then replay forever; clear overrides both
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        frame_done_d = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_fire) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        state_d  = ST_REPLAY;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
            end
            ST_REPLAY: begin
                if (weight_fire) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        rd_ptr_d     = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        if (clear) begin
            state_d      = ST_LOAD;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            frame_done_d = 1'b0;
            mem_we       = 1'b0;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Weight storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[wr_ptr_q] <= bus.load_data;
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.weight_valid = weight_valid;
    assign bus.loaded       = weight_valid;
    assign bus.weight_data  = mem_q[rd_ptr_q];
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_norm_weight_replay_buffer.sv
// Self-checking bench for norm_weight_replay_buffer (default parameters:
// 8 tiles of 4 elements). Loaded tiles are pushed to a scoreboard queue and
// popped/compared (then re-queued, since replay is cyclic) on every replay handshake.
module tb_norm_weight_replay_buffer;
    localparam int N         = 4;
    localparam int SW        = 8;
    localparam int NUM_ITERS = 8;

    typedef logic [N-1:0][SW-1:0] tile_t;

    logic clk;
    logic rst;
    logic clear;

    norm_weight_replay_buffer_if #(.N(N), .SCALE_WIDTH(SW)) bus ();

    norm_weight_replay_buffer #(
        .TOTAL_DIM0(4), .TOTAL_DIM1(4), .COMPUTE_DIM0(2), .COMPUTE_DIM1(2),
        .CHANNELS(2), .SCALE_WIDTH(SW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    tile_t exp_q[$];
    int    pos         = 0;
    bit    fd_exp      = 1'b0;
    int    fd_seen     = 0;
    int    fd_cnt_exp  = 0;

    function automatic tile_t make_tile(input int base, input int k);
        tile_t t;
        for (int i = 0; i < N; i++) t[i] = SW'(base + 8 * k + i);
        return t;
    endfunction

    // Loads one frame starting at a negedge, with optional random load_valid gaps
    task automatic load_frame(input int base, input bit gaps);
        int k;
        int guard;
        k     = 0;
        guard = 0;
        exp_q.delete();
        pos    = 0;
        fd_exp = 1'b0;
        while (k < NUM_ITERS && guard < 200) begin
            vectors++;
            if (bus.load_ready !== 1'b1 || bus.weight_valid !== 1'b0 || bus.loaded !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL load_status beat %0d: ready=%b valid=%b loaded=%b, want 1 0 0",
                         k, bus.load_ready, bus.weight_valid, bus.loaded);
            end
            bus.load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.load_data  = make_tile(base, k);
            if (bus.load_valid) begin
                exp_q.push_back(bus.load_data);
                k++;
            end
            @(negedge clk);
            guard++;
        end
        bus.load_valid = 1'b0;
        if (guard >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL load_timeout: beats=%0d, want %0d", k, NUM_ITERS);
        end
    endtask

    // Consumes replay tiles for ncyc cycles, checking order, stall stability and frame_done
    task automatic consume(input int ncyc, input bit rnd, input bit drive_load);
        tile_t held;
        tile_t exp;
        bit    stalled;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < ncyc; c++) begin
            vectors++;
            if (bus.weight_valid !== 1'b1 || bus.loaded !== 1'b1 || bus.load_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL replay_status cyc %0d: valid=%b loaded=%b ready=%b, want 1 1 0",
                         c, bus.weight_valid, bus.loaded, bus.load_ready);
            end
            vectors++;
            if (bus.frame_done !== fd_exp) begin
                miscompares++;
                $display("[TB] FAIL frame_done cyc %0d: got %b, want %b", c, bus.frame_done, fd_exp);
            end
            if (bus.frame_done === 1'b1) fd_seen++;
            if (stalled) begin
                vectors++;
                if (bus.weight_data !== held) begin
                    miscompares++;
                    $display("[TB] FAIL stall_stable cyc %0d: got %h, want %h", c, bus.weight_data, held);
                end
            end
            bus.weight_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drive_load) begin
                bus.load_valid = 1'b1;
                bus.load_data  = {N{8'hEE}};
            end
            if (bus.weight_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL scoreboard_empty cyc %0d: got %h", c, bus.weight_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.weight_data !== exp) begin
                        miscompares++;
                        $display("[TB] FAIL replay_data pos %0d: got %h, want %h", pos, bus.weight_data, exp);
                    end
                    exp_q.push_back(exp);
                end
                fd_exp = (pos == NUM_ITERS - 1);
                if (fd_exp) fd_cnt_exp++;
                pos     = (pos + 1) % NUM_ITERS;
                stalled = 1'b0;
            end else begin
                fd_exp  = 1'b0;
                stalled = 1'b1;
                held    = bus.weight_data;
            end
            @(negedge clk);
        end
        bus.weight_ready = 1'b0;
        bus.load_valid   = 1'b0;
        vectors++;
        if (bus.frame_done !== fd_exp) begin
            miscompares++;
            $display("[TB] FAIL frame_done_tail: got %b, want %b", bus.frame_done, fd_exp);
        end
        if (bus.frame_done === 1'b1) fd_seen++;
        fd_exp = 1'b0;
    endtask

    task automatic check_idle(input string name, input logic want_ready);
        vectors++;
        if (bus.load_ready !== want_ready || bus.weight_valid !== 1'b0 ||
            bus.loaded !== 1'b0 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s: ready=%b valid=%b loaded=%b done=%b, want %b 0 0 0", name,
                     bus.load_ready, bus.weight_valid, bus.loaded, bus.frame_done, want_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset_hold", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_release", 1'b1);
    endtask

    task automatic test_load_and_replay();
        fd_seen    = 0;
        fd_cnt_exp = 0;
        load_frame(0, 1'b0);
        consume(24, 1'b0, 1'b0);
        vectors++;
        if (fd_seen != 3) begin
            miscompares++;
            $display("[TB] FAIL frame_done_count: got %0d, want 3", fd_seen);
        end
    endtask

    task automatic test_random_backpressure();
        test_reset();
        fd_seen    = 0;
        fd_cnt_exp = 0;
        load_frame(0, 1'b1);
        consume(48, 1'b1, 1'b0);
        vectors++;
        if (fd_seen != fd_cnt_exp) begin
            miscompares++;
            $display("[TB] FAIL random_frame_count: got %0d, want %0d", fd_seen, fd_cnt_exp);
        end
        consume(8, 1'b0, 1'b1);
    endtask

    task automatic test_clear();
        test_reset();
        load_frame(0, 1'b0);
        consume(5, 1'b0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle("clear_after_5", 1'b1);
        load_frame(100, 1'b0);
        vectors++;
        if (bus.weight_data !== make_tile(100, 0)) begin
            miscompares++;
            $display("[TB] FAIL reload_first_tile: got %h, want %h", bus.weight_data, make_tile(100, 0));
        end
        consume(15, 1'b0, 1'b0);
        clear            = 1'b1;
        bus.weight_ready = 1'b1;
        @(negedge clk);
        clear            = 1'b0;
        bus.weight_ready = 1'b0;
        check_idle("clear_on_last_tile", 1'b1);
    endtask

    task automatic test_reset_mid_load();
        test_reset();
        for (int k = 0; k < 3; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = make_tile(0, k);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset_mid_load", 1'b0);
        @(negedge clk);
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        @(negedge clk);
        check_idle("reset_mid_load_release", 1'b1);
        load_frame(40, 1'b0);
        consume(8, 1'b0, 1'b0);
    endtask

    initial begin
        rst              = 1'b0;
        clear            = 1'b0;
        bus.load_valid   = 1'b0;
        bus.load_data    = '0;
        bus.weight_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_and_replay();
        test_random_backpressure();
        test_clear();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
